// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the 3-stage RISC-V pipeline.
//
// Holds the PC and keeps at most one fetch outstanding to instruction memory.
// Requests use valid/ready; responses are valid-only. A one-entry skid buffer
// catches a response that lands while decode is stalled. A flush redirects the
// PC to the branch target and squashes everything on the wrong path. This
// includes a fetch still in flight, whose late response is then dropped.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush, br_target  redirect request and target address (bits [1:0] ignored)
//   stall             downstream hold; output registers keep their value
//   imem_req_valid    fetch request (combinational, allows back-to-back issue)
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         fetch address, always the PC register
//   imem_rsp_valid    response present (one cycle, at least one after accept)
//   imem_rsp_data     fetched instruction
//   pc_out, inst_out  registered PC and instruction to decode
//   inst_valid        inst_out is a real instruction (otherwise inst_out = NOP)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  localparam logic [1:0] S_REQ  = 2'd0;  // no request outstanding
  localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding
  localparam logic [1:0] S_HOLD = 2'd2;  // response parked in skid buffer

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic        drop_r;
  logic [31:0] req_pc_r;
  logic [31:0] buf_inst_r;
  logic [31:0] buf_pc_r;

  logic        req_valid_s;
  logic        req_fire_s;
  logic        rsp_take_s;
  logic [31:0] pc_inc_s;

  assign imem_addr = pc_r;
  assign pc_inc_s  = pc_r + 32'd4;   // wraps modulo 2^32

  // A response is consumed when it is dropped or goes straight to the outputs;
  // only then may the next request be issued in the same cycle.
  always_comb begin
    rsp_take_s = (state_r == S_WAIT) && imem_rsp_valid && (drop_r || !stall);
  end

  // Request generation; suppressed during reset and in the flush cycle.
  always_comb begin
    req_valid_s = 1'b0;
    if (rst || flush) begin
      req_valid_s = 1'b0;
    end else begin
      case (state_r)
        S_REQ:   req_valid_s = 1'b1;
        S_WAIT:  req_valid_s = rsp_take_s;
        S_HOLD:  req_valid_s = 1'b0;
        default: req_valid_s = 1'b0;
      endcase
    end
  end

  assign req_fire_s     = req_valid_s && imem_req_ready;
  assign imem_req_valid = req_valid_s;

  // Fetch state machine, PC, skid buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_REQ;
      pc_r       <= RESET_PC;
      drop_r     <= 1'b0;
      req_pc_r   <= 32'd0;
      buf_inst_r <= NOP;
      buf_pc_r   <= 32'd0;
      pc_out     <= 32'd0;
      inst_out   <= NOP;
      inst_valid <= 1'b0;
    end else if (flush) begin
      pc_r       <= {br_target[31:2], 2'b00};
      inst_valid <= 1'b0;
      inst_out   <= NOP;
      buf_inst_r <= NOP;
      buf_pc_r   <= 32'd0;
      // A fetch still in flight must have its response thrown away later;
      // if the response is here right now it is simply ignored.
      if ((state_r == S_WAIT) && !imem_rsp_valid) begin
        state_r <= S_WAIT;
        drop_r  <= 1'b1;
      end else begin
        state_r <= S_REQ;
        drop_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        S_REQ: begin
          if (req_fire_s) begin
            req_pc_r <= pc_r;
            pc_r     <= pc_inc_s;
            state_r  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_r) begin
              drop_r <= 1'b0;
            end else if (!stall) begin
              pc_out     <= req_pc_r;
              inst_out   <= imem_rsp_data;
              inst_valid <= 1'b1;
            end else begin
              buf_inst_r <= imem_rsp_data;
              buf_pc_r   <= req_pc_r;
              state_r    <= S_HOLD;
            end
            if (rsp_take_s) begin
              if (req_fire_s) begin
                req_pc_r <= pc_r;
                pc_r     <= pc_inc_s;
                state_r  <= S_WAIT;
              end else begin
                state_r  <= S_REQ;
              end
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_out     <= buf_pc_r;
            inst_out   <= buf_inst_r;
            inst_valid <= 1'b1;
            state_r    <= S_REQ;
          end
        end
        default: state_r <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 3-stage RISC-V pipeline. Holds the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request and valid-only response interface. Delivers registered {pc, instruction, valid} to decode/execute. Consumes `flush` and the branch target from the execute stage and forwarding unit, squashing wrong-path instructions, including a fetch already in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- NOP, 32'h0000_0013: bubble instruction (addi x0,x0,0) driven when invalid.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  branch taken; redirect fetch and squash.
- br_target  in  32  redirect address; bits [1:0] ignored (forced 0).
- stall  in  1  downstream hold; output register must not change.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  response data present; at least 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- pc_out  out  32  PC of `inst_out`.
- inst_out  out  32  instruction to decode.
- inst_valid  out  1  `inst_out` is a real instruction.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `state`.
  - `drop`: the in-flight response is stale.
  - `buf_inst`, `buf_pc`: skid buffer.
  - `req_pc`: PC of the outstanding request.
  - Output regs `pc_out`, `inst_out`, `inst_valid`.
- `imem_addr = pc` always.
- States:
  - S_REQ, no request outstanding:
    - `imem_req_valid=1` unless `flush`.
    - On `req_valid & req_ready`: latch `req_pc <= pc`, set `pc <= pc+4`, go to S_WAIT.
  - S_WAIT, one request outstanding. On `rsp_valid`:
    - If `drop`: discard the data, clear `drop`.
    - Else if `!stall`: load outputs with {`req_pc`, `rsp_data`, valid=1}.
    - Else: load the skid buffer and go to S_HOLD.
    - When the response is consumed (dropped or loaded) and there is no flush, `imem_req_valid=1` in the same cycle (back-to-back). If it is accepted, stay in S_WAIT with the new `req_pc`; otherwise go to S_REQ.
  - S_HOLD, buffered instruction waiting on stall. `imem_req_valid=0`. When `stall` falls, move the buffer to the outputs and go to S_REQ.
- Stall: while `stall=1` and there is no flush, the output registers hold.
- Flush (highest priority, overrides `stall`):
  - `pc <= {br_target[31:2],2'b00}`.
  - `inst_valid <= 0`, `inst_out <= NOP`, skid buffer discarded.
  - `imem_req_valid` forced 0 in the flush cycle.
  - From S_WAIT with no `rsp_valid` this cycle: stay in S_WAIT with `drop <= 1`.
  - From S_WAIT with `rsp_valid` this cycle: the response is discarded, go to S_REQ, `drop` stays 0.
  - From S_REQ or S_HOLD: go to S_REQ.
- Whenever `inst_valid=0`, `inst_out=NOP`.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 → 0x0000_0000.

## Timing
- Reset values (outputs):
  - `pc_out=0`, `inst_out=NOP`, `inst_valid=0`.
  - `imem_req_valid=0` while `rst=1`.
  - `imem_addr=RESET_PC`.
- Reset values (internal): `pc=RESET_PC`, `state=S_REQ`, `drop=0`.
- Reset mid-operation (any state) returns everything to reset values next edge. Instruction memory shares `rst`, so no pre-reset response arrives afterwards.
- Latency: request accepted at cycle N, response at cycle N+k (k≥1), outputs valid at N+k+1.
- Throughput with `ready=1` and k=1: one instruction per cycle after a 2-cycle fill.
- Flush at cycle F: `inst_valid=0` at F+1; first target request at F+1 (or after the stale response drains). Target instruction visible no earlier than F+3.
- Responses are never lost or duplicated under any stall pattern.

## Test plan
- Reset, `ready=1`, k=1, memory returns `addr ^ 0xA5A5_0000`: release rst at cycle 0 → requests to 0,4,8 in cycles 0,1,2; `inst_valid` from cycle 2; `pc_out` 0,4,8 in consecutive cycles with matching data.
- `stall=1` for 3 cycles while the response for 0x8 arrives → outputs hold at 0x4; no request issued in S_HOLD. When `stall=0`, `pc_out=0x8` next cycle, then 0xC; no duplicates.
- `flush`, `br_target=0x103`, while the request for 0x10 is outstanding (no `rsp_valid` in the flush cycle) → `inst_valid=0` next cycle. The late 0x10 response is dropped; the next request is to 0x100, and `pc_out=0x100` is the first valid output.
- `flush` in the same cycle as `rsp_valid` → data discarded; next request to the target, no stale `inst_valid`.
- `RESET_PC=0xFFFF_FFF8`, `ready=1` → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- `imem_req_ready` held low 4 cycles, then `rst` pulsed in S_WAIT → `imem_addr` stable while stalled. After reset: outputs NOP/invalid and the fetch restarts at RESET_PC.
